cordic_result_unloader: RTL and testbench

//  - Receiving end of the CORDIC test wrapper output stream (o_vld/o_data).
//  - Captures each DATA_WIDTH result word into a FIFO and serializes it to the host as BEAT_WIDTH beats.
//  - Serial side uses a valid/ready handshake. Result side has no backpressure.
//  - Tracks dropped words and sent words for post-run readout.

---
 rtl/cordic_unload_pkg.sv | 10 +
 rtl/cordic_result_unloader_fifo.sv | 46 ++++
 rtl/cordic_result_unloader.sv | 130 +++++++++++++
 tb/tb_cordic_result_unloader.sv | 359 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cordic_unload_pkg.sv
// Shared types and helpers for the CORDIC result unloader.
package cordic_unload_pkg;

  typedef enum logic {ST_IDLE, ST_SEND} unload_state_e;

  function automatic int unsigned num_beats(input int unsigned dw, input int unsigned bw);
    return (dw + bw - 1) / bw;
  endfunction

endpackage

// File: rtl/cordic_result_unloader_fifo.sv
// Synchronous FIFO with wrap-bit pointers; read data is the head entry, combinational.
module sync_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

  // A full FIFO still accepts a push when the head leaves in the same cycle.
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign rdata   = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= wdata;
  end

endmodule

// File: rtl/cordic_result_unloader.sv
// Buffers CORDIC result words and serializes them LSB-first as valid/ready beats.
module cordic_result_unloader
  import cordic_unload_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 54,
  parameter int unsigned BEAT_WIDTH = 8,
  parameter int unsigned FIFO_DEPTH = 8,
  parameter int unsigned CNT_WIDTH  = 16
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_res_vld,
  input  logic [DATA_WIDTH-1:0] i_res_data,
  input  logic                  i_clr_ovf,
  output logic                  o_beat_vld,
  output logic [BEAT_WIDTH-1:0] o_beat_data,
  output logic                  o_beat_last,
  input  logic                  i_beat_rdy,
  output logic                  o_overflow,
  output logic [CNT_WIDTH-1:0]  o_drop_cnt,
  output logic [CNT_WIDTH-1:0]  o_word_cnt,
  output logic                  o_busy
);

  localparam int unsigned NB = num_beats(DATA_WIDTH, BEAT_WIDTH);
  localparam int unsigned SW = NB * BEAT_WIDTH;
  localparam int unsigned IW = (NB > 1) ? $clog2(NB) : 1;

  unload_state_e         state_q, state_d;
  logic [SW-1:0]         shift_q, shift_d;
  logic [IW-1:0]         idx_q, idx_d;
  logic                  word_done;
  logic                  fifo_pop;
  logic                  fifo_full;
  logic                  fifo_empty;
  logic [DATA_WIDTH-1:0] fifo_rdata;
  logic                  hs;
  logic                  is_last;
  logic                  drop;

  sync_fifo #(
    .WIDTH (DATA_WIDTH),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (i_clk),
    .rst   (i_rst),
    .push  (i_res_vld),
    .pop   (fifo_pop),
    .wdata (i_res_data),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign hs      = (state_q == ST_SEND) & i_beat_rdy;
  assign is_last = (idx_q == IW'(NB - 1));
  assign drop    = i_res_vld & fifo_full & ~fifo_pop;

  always_comb begin
    state_d   = state_q;
    shift_d   = shift_q;
    idx_d     = idx_q;
    fifo_pop  = 1'b0;
    word_done = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (!fifo_empty) begin
          fifo_pop = 1'b1;
          shift_d  = SW'(fifo_rdata);
          idx_d    = '0;
          state_d  = ST_SEND;
        end
      end
      ST_SEND: begin
        if (hs) begin
          if (is_last) begin
            word_done = 1'b1;
            // Reload straight from the head so consecutive words have no bubble.
            if (!fifo_empty) begin
              fifo_pop = 1'b1;
              shift_d  = SW'(fifo_rdata);
              idx_d    = '0;
            end else begin
              state_d = ST_IDLE;
            end
          end else begin
            shift_d = shift_q >> BEAT_WIDTH;
            idx_d   = idx_q + 1'b1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= ST_IDLE;
      shift_q <= '0;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      idx_q   <= idx_d;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      o_overflow <= 1'b0;
      o_drop_cnt <= '0;
      o_word_cnt <= '0;
    end else begin
      if (i_clr_ovf) begin
        o_overflow <= 1'b0;
        o_drop_cnt <= '0;
      end else if (drop) begin
        o_overflow <= 1'b1;
        if (o_drop_cnt != '1) o_drop_cnt <= o_drop_cnt + 1'b1;
      end
      if (word_done) o_word_cnt <= o_word_cnt + 1'b1;
    end
  end

  assign o_beat_vld  = (state_q == ST_SEND);
  assign o_beat_data = shift_q[BEAT_WIDTH-1:0];
  assign o_beat_last = (state_q == ST_SEND) & is_last;
  assign o_busy      = ~fifo_empty | (state_q == ST_SEND);

endmodule

// File: tb/tb_cordic_result_unloader.sv
// Directed self-checking bench for cordic_result_unloader at default parameters.
module tb_cordic_result_unloader;

  logic        i_clk;
  logic        i_rst;
  logic        i_res_vld;
  logic [53:0] i_res_data;
  logic        i_clr_ovf;
  logic        o_beat_vld;
  logic [7:0]  o_beat_data;
  logic        o_beat_last;
  logic        i_beat_rdy;
  logic        o_overflow;
  logic [15:0] o_drop_cnt;
  logic [15:0] o_word_cnt;
  logic        o_busy;

  int unsigned checks;
  int unsigned failures;
  logic [53:0] w [10];

  cordic_result_unloader #(
    .DATA_WIDTH (54),
    .BEAT_WIDTH (8),
    .FIFO_DEPTH (8),
    .CNT_WIDTH  (16)
  ) dut (
    .i_clk       (i_clk),
    .i_rst       (i_rst),
    .i_res_vld   (i_res_vld),
    .i_res_data  (i_res_data),
    .i_clr_ovf   (i_clr_ovf),
    .o_beat_vld  (o_beat_vld),
    .o_beat_data (o_beat_data),
    .o_beat_last (o_beat_last),
    .i_beat_rdy  (i_beat_rdy),
    .o_overflow  (o_overflow),
    .o_drop_cnt  (o_drop_cnt),
    .o_word_cnt  (o_word_cnt),
    .o_busy      (o_busy)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  function automatic logic [7:0] byte_of(input logic [53:0] word, input int unsigned k);
    logic [55:0] x;
    x = {2'b00, word};
    return x[k*8 +: 8];
  endfunction

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic do_reset();
    i_rst      = 1'b1;
    i_res_vld  = 1'b0;
    i_res_data = '0;
    i_clr_ovf  = 1'b0;
    i_beat_rdy = 1'b0;
    tick();
    i_rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if ({o_beat_vld, o_beat_data, o_beat_last} !== 10'd0) begin
      failures++;
      $display("FAIL reset_beat got vld=%b data=%h last=%b want 0", o_beat_vld, o_beat_data, o_beat_last);
    end
    checks++;
    if ({o_overflow, o_drop_cnt, o_word_cnt, o_busy} !== 34'd0) begin
      failures++;
      $display("FAIL reset_status got ovf=%b drop=%0d words=%0d busy=%b want 0", o_overflow, o_drop_cnt, o_word_cnt, o_busy);
    end
  endtask

  task automatic test_single_word();
    logic [7:0] exp_b [7];
    exp_b = '{8'h67, 8'h45, 8'h23, 8'h01, 8'h55, 8'h55, 8'h2A};
    do_reset();
    i_beat_rdy = 1'b1;
    i_res_vld  = 1'b1;
    i_res_data = 54'h2A_5555_0123_4567;
    tick();
    i_res_vld = 1'b0;
    checks++;
    if (o_beat_vld !== 1'b0 || o_busy !== 1'b1) begin
      failures++;
      $display("FAIL single_latency1 got vld=%b busy=%b want vld=0 busy=1", o_beat_vld, o_busy);
    end
    tick();
    for (int k = 0; k < 7; k++) begin
      checks++;
      if (o_beat_vld !== 1'b1 || o_beat_data !== exp_b[k] || o_beat_last !== (k == 6)) begin
        failures++;
        $display("FAIL single_beat%0d got vld=%b data=%h last=%b want vld=1 data=%h last=%b",
                 k, o_beat_vld, o_beat_data, o_beat_last, exp_b[k], (k == 6));
      end
      tick();
    end
    checks++;
    if (o_beat_vld !== 1'b0 || o_word_cnt !== 16'd1 || o_busy !== 1'b0) begin
      failures++;
      $display("FAIL single_done got vld=%b words=%0d busy=%b want vld=0 words=1 busy=0", o_beat_vld, o_word_cnt, o_busy);
    end
  endtask

  task automatic test_backpressure();
    logic [53:0] wd;
    wd = 54'h3F_DCBA_9876_5432;
    do_reset();
    i_beat_rdy = 1'b1;
    i_res_vld  = 1'b1;
    i_res_data = wd;
    tick();
    i_res_vld = 1'b0;
    tick();
    for (int k = 0; k < 7; k++) begin
      if (k == 3) begin
        i_beat_rdy = 1'b0;
        for (int s = 0; s < 5; s++) begin
          checks++;
          if (o_beat_vld !== 1'b1 || o_beat_data !== 8'h98 || o_beat_last !== 1'b0) begin
            failures++;
            $display("FAIL bp_hold%0d got vld=%b data=%h last=%b want vld=1 data=98 last=0",
                     s, o_beat_vld, o_beat_data, o_beat_last);
          end
          tick();
        end
        i_beat_rdy = 1'b1;
      end
      checks++;
      if (o_beat_vld !== 1'b1 || o_beat_data !== byte_of(wd, k) || o_beat_last !== (k == 6)) begin
        failures++;
        $display("FAIL bp_beat%0d got vld=%b data=%h last=%b want vld=1 data=%h last=%b",
                 k, o_beat_vld, o_beat_data, o_beat_last, byte_of(wd, k), (k == 6));
      end
      tick();
    end
    checks++;
    if (o_beat_vld !== 1'b0 || o_word_cnt !== 16'd1) begin
      failures++;
      $display("FAIL bp_done got vld=%b words=%0d want vld=0 words=1", o_beat_vld, o_word_cnt);
    end
  endtask

  task automatic test_back_to_back();
    int unsigned b;
    w[0] = 54'h11_2233_4455_6677;
    w[1] = 54'h08_99AA_BBCC_DDEE;
    w[2] = 54'h3C_0F1E_2D3C_4B5A;
    do_reset();
    i_beat_rdy = 1'b1;
    for (int i = 0; i <= 22; i++) begin
      if (i < 3) begin
        i_res_vld  = 1'b1;
        i_res_data = w[i];
      end else begin
        i_res_vld = 1'b0;
      end
      tick();
      if (i == 0) begin
        checks++;
        if (o_beat_vld !== 1'b0) begin
          failures++;
          $display("FAIL b2b_first got vld=%b want 0", o_beat_vld);
        end
      end else if (i <= 21) begin
        b = i - 1;
        checks++;
        if (o_beat_vld !== 1'b1 || o_beat_data !== byte_of(w[b/7], b%7) || o_beat_last !== (b%7 == 6)) begin
          failures++;
          $display("FAIL b2b_beat%0d got vld=%b data=%h last=%b want vld=1 data=%h last=%b",
                   b, o_beat_vld, o_beat_data, o_beat_last, byte_of(w[b/7], b%7), (b%7 == 6));
        end
        if (b == 20) begin
          checks++;
          if (o_busy !== 1'b1) begin
            failures++;
            $display("FAIL b2b_busy_last got %b want 1", o_busy);
          end
        end
      end else begin
        checks++;
        if (o_beat_vld !== 1'b0 || o_word_cnt !== 16'd3 || o_busy !== 1'b0) begin
          failures++;
          $display("FAIL b2b_done got vld=%b words=%0d busy=%b want vld=0 words=3 busy=0", o_beat_vld, o_word_cnt, o_busy);
        end
      end
    end
  endtask

  task automatic test_overflow();
    int unsigned b;
    for (int i = 0; i < 10; i++) w[i] = 54'h15_2233_4455_6677 + 54'(i) * 54'h01_0101_0101_0101;
    do_reset();
    for (int i = 0; i < 10; i++) begin
      i_res_vld  = 1'b1;
      i_res_data = w[i];
      tick();
      if (i == 8) begin
        checks++;
        if (o_overflow !== 1'b0 || o_drop_cnt !== 16'd0) begin
          failures++;
          $display("FAIL ovf_before got ovf=%b drop=%0d want 0 0", o_overflow, o_drop_cnt);
        end
      end
    end
    i_res_vld = 1'b0;
    checks++;
    if (o_overflow !== 1'b1 || o_drop_cnt !== 16'd1 || o_word_cnt !== 16'd0 || o_busy !== 1'b1) begin
      failures++;
      $display("FAIL ovf_after got ovf=%b drop=%0d words=%0d busy=%b want 1 1 0 1", o_overflow, o_drop_cnt, o_word_cnt, o_busy);
    end
    // clear on the same cycle as another dropped push
    i_res_vld  = 1'b1;
    i_res_data = 54'h3F_FFFF_FFFF_FFFF;
    i_clr_ovf  = 1'b1;
    tick();
    i_res_vld = 1'b0;
    i_clr_ovf = 1'b0;
    checks++;
    if (o_overflow !== 1'b0 || o_drop_cnt !== 16'd0) begin
      failures++;
      $display("FAIL ovf_clear got ovf=%b drop=%0d want 0 0", o_overflow, o_drop_cnt);
    end
    i_beat_rdy = 1'b1;
    for (b = 0; b < 63; b++) begin
      checks++;
      if (o_beat_vld !== 1'b1 || o_beat_data !== byte_of(w[b/7], b%7) || o_beat_last !== (b%7 == 6)) begin
        failures++;
        $display("FAIL ovf_drain%0d got vld=%b data=%h last=%b want vld=1 data=%h last=%b",
                 b, o_beat_vld, o_beat_data, o_beat_last, byte_of(w[b/7], b%7), (b%7 == 6));
      end
      tick();
    end
    checks++;
    if (o_beat_vld !== 1'b0 || o_word_cnt !== 16'd9 || o_busy !== 1'b0) begin
      failures++;
      $display("FAIL ovf_done got vld=%b words=%0d busy=%b want vld=0 words=9 busy=0", o_beat_vld, o_word_cnt, o_busy);
    end
  endtask

  task automatic test_full_pop();
    int unsigned b;
    for (int i = 0; i < 10; i++) w[i] = 54'h2B_1020_3040_5060 + 54'(i) * 54'h00_0102_0304_0506;
    do_reset();
    for (int i = 0; i < 9; i++) begin
      i_res_vld  = 1'b1;
      i_res_data = w[i];
      tick();
    end
    i_res_vld  = 1'b0;
    i_beat_rdy = 1'b1;
    for (int k = 0; k < 6; k++) begin
      checks++;
      if (o_beat_vld !== 1'b1 || o_beat_data !== byte_of(w[0], k)) begin
        failures++;
        $display("FAIL fp_beat%0d got vld=%b data=%h want vld=1 data=%h", k, o_beat_vld, o_beat_data, byte_of(w[0], k));
      end
      tick();
    end
    checks++;
    if (o_beat_last !== 1'b1) begin
      failures++;
      $display("FAIL fp_last got %b want 1", o_beat_last);
    end
    i_res_vld  = 1'b1;
    i_res_data = w[9];
    tick();
    i_res_vld = 1'b0;
    checks++;
    if (o_overflow !== 1'b0 || o_drop_cnt !== 16'd0 || o_word_cnt !== 16'd1) begin
      failures++;
      $display("FAIL fp_accept got ovf=%b drop=%0d words=%0d want 0 0 1", o_overflow, o_drop_cnt, o_word_cnt);
    end
    for (b = 0; b < 63; b++) begin
      checks++;
      if (o_beat_vld !== 1'b1 || o_beat_data !== byte_of(w[1 + b/7], b%7) || o_beat_last !== (b%7 == 6)) begin
        failures++;
        $display("FAIL fp_drain%0d got vld=%b data=%h last=%b want vld=1 data=%h last=%b",
                 b, o_beat_vld, o_beat_data, o_beat_last, byte_of(w[1 + b/7], b%7), (b%7 == 6));
      end
      tick();
    end
    checks++;
    if (o_beat_vld !== 1'b0 || o_word_cnt !== 16'd10 || o_busy !== 1'b0) begin
      failures++;
      $display("FAIL fp_done got vld=%b words=%0d busy=%b want vld=0 words=10 busy=0", o_beat_vld, o_word_cnt, o_busy);
    end
  endtask

  // Runs after test_full_pop without its own reset so the counters start non-zero.
  task automatic test_reset_mid_word();
    w[0] = 54'h2A_5555_0123_4567;
    w[1] = 54'h01_8081_8283_8485;
    i_beat_rdy = 1'b1;
    i_res_vld  = 1'b1;
    i_res_data = w[0];
    tick();
    i_res_vld = 1'b0;
    tick();
    for (int k = 0; k < 3; k++) begin
      checks++;
      if (o_beat_vld !== 1'b1 || o_beat_data !== byte_of(w[0], k)) begin
        failures++;
        $display("FAIL rm_beat%0d got vld=%b data=%h want vld=1 data=%h", k, o_beat_vld, o_beat_data, byte_of(w[0], k));
      end
      tick();
    end
    i_rst = 1'b1;
    tick();
    i_rst = 1'b0;
    checks++;
    if ({o_beat_vld, o_beat_data, o_beat_last, o_overflow, o_drop_cnt, o_word_cnt, o_busy} !== 44'd0) begin
      failures++;
      $display("FAIL rm_reset got vld=%b data=%h last=%b ovf=%b drop=%0d words=%0d busy=%b want all 0",
               o_beat_vld, o_beat_data, o_beat_last, o_overflow, o_drop_cnt, o_word_cnt, o_busy);
    end
    i_res_vld  = 1'b1;
    i_res_data = w[1];
    tick();
    i_res_vld = 1'b0;
    tick();
    for (int k = 0; k < 7; k++) begin
      checks++;
      if (o_beat_vld !== 1'b1 || o_beat_data !== byte_of(w[1], k) || o_beat_last !== (k == 6)) begin
        failures++;
        $display("FAIL rm_fresh%0d got vld=%b data=%h last=%b want vld=1 data=%h last=%b",
                 k, o_beat_vld, o_beat_data, o_beat_last, byte_of(w[1], k), (k == 6));
      end
      tick();
    end
    checks++;
    if (o_beat_vld !== 1'b0 || o_word_cnt !== 16'd1) begin
      failures++;
      $display("FAIL rm_done got vld=%b words=%0d want vld=0 words=1", o_beat_vld, o_word_cnt);
    end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    test_reset();
    test_single_word();
    test_backpressure();
    test_back_to_back();
    test_overflow();
    test_full_pop();
    test_reset_mid_word();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
